// File: rtl/canvas_scanout.sv
// Canvas read-side scanout: fetches one display line from the canvas RAM and
// streams it out as {alpha, color} cells through a small credit-managed FIFO.
module canvas_scanout #(
    parameter int SCREEN_W   = 320,
    parameter int SCREEN_H   = 240,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        line_start,
    input  logic [7:0]  line_num,
    input  logic [3:0]  scroll_x,
    input  logic [3:0]  scroll_y,
    output logic        busy,
    output logic [16:0] canvas_addr,
    output logic        canvas_re,
    input  logic [9:0]  canvas_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [9:0]  pix_data,
    output logic        pix_last,
    output logic        line_done
);
    localparam int XW = $clog2(SCREEN_W + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

    state_e          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [3:0]      col0_q, col0_d;
    logic [7:0]      row_q, row_d;
    logic            re_q, re_d;
    logic            re_last_q, re_last_d;
    logic            pend_q, pend_last_q;
    logic [16:0]     addr_q, addr_d;

    logic [10:0]     mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   cnt_q;
    logic [10:0]     head;
    logic            push, pop, credit;
    logic [CW:0]     occ;

    assign push      = pend_q;
    assign pix_valid = (cnt_q != '0);
    assign pop       = pix_valid & pix_ready;
    assign head      = mem_q[rptr_q];
    assign pix_data  = head[9:0];
    assign pix_last  = pix_valid & head[10];
    assign line_done = (state_q == DRAIN) & pop & head[10];
    assign busy      = (state_q != IDLE);
    assign canvas_re   = re_q;
    assign canvas_addr = addr_q;

    // Occupancy counts FIFO entries plus both read-pipeline stages, net of
    // this cycle's pop, so a read issued now always has a slot waiting.
    assign occ    = {1'b0, cnt_q} + (CW+1)'(re_q) + (CW+1)'(pend_q) - (CW+1)'(pop);
    assign credit = occ < (CW+1)'(FIFO_DEPTH);

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        col0_d    = col0_q;
        row_d     = row_q;
        re_d      = 1'b0;
        re_last_d = 1'b0;
        addr_d    = addr_q;
        unique case (state_q)
            IDLE: begin
                // The first read goes out on the accepting edge so canvas_re
                // appears one cycle after line_start.
                if (line_start && ({1'b0, line_num} < 9'(SCREEN_H))) begin
                    state_d = FETCH;
                    col0_d  = scroll_x;
                    row_d   = line_num + {4'b0, scroll_y};
                    re_d    = 1'b1;
                    addr_d  = {9'(scroll_x), row_d};
                    x_d     = XW'(1);
                end
            end
            FETCH: begin
                if (credit) begin
                    re_d      = 1'b1;
                    addr_d    = {9'(col0_q) + 9'(x_q), row_q};
                    re_last_d = (x_q == XW'(SCREEN_W - 1));
                    x_d       = x_q + XW'(1);
                    if (x_q == XW'(SCREEN_W - 1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (line_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            x_q         <= '0;
            col0_q      <= '0;
            row_q       <= '0;
            re_q        <= 1'b0;
            re_last_q   <= 1'b0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            addr_q      <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            col0_q      <= col0_d;
            row_q       <= row_d;
            re_q        <= re_d;
            re_last_q   <= re_last_d;
            pend_q      <= re_q;
            pend_last_q <= re_last_q;
            addr_q      <= addr_d;
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop)  rptr_q <= rptr_q + PW'(1);
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= {pend_last_q, canvas_data};
    end
endmodule

// File: tb/tb_canvas_scanout.sv
// Scoreboarded bench for canvas_scanout: directed lines queue expected reads and
// pixels; a negedge monitor checks every read, handshake and stall.
module tb_canvas_scanout;
    logic        clk = 1'b0;
    logic        reset, line_start;
    logic [7:0]  line_num;
    logic [3:0]  scroll_x, scroll_y;
    logic        busy, canvas_re, pix_valid, pix_last, line_done;
    logic        pix_ready = 1'b1;
    logic [16:0] canvas_addr;
    logic [9:0]  canvas_data = '0;
    logic [9:0]  pix_data;

    canvas_scanout dut (
        .clk(clk), .reset(reset), .line_start(line_start), .line_num(line_num),
        .scroll_x(scroll_x), .scroll_y(scroll_y), .busy(busy),
        .canvas_addr(canvas_addr), .canvas_re(canvas_re), .canvas_data(canvas_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_last(pix_last), .line_done(line_done)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, cyc = 0;
    logic [10:0] exp_pix[$];
    logic [16:0] exp_addr[$];
    int pops = 0, issued = 0, done_cnt = 0, last_cnt = 0, line_reads = 0;
    int t0 = 0, t_fv = 0, t_last = 0, t_done = 0;
    bit fv_seen = 1'b0, rnd_ready = 1'b0, prev_stall = 1'b0;
    logic [10:0] prev_head = '0, e_pix;
    logic [16:0] first_addr = '0, last_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Canvas stores {col[4:0], row[4:0]} per cell, one-cycle read latency
    always @(posedge clk) if (canvas_re) canvas_data <= {canvas_addr[12:8], canvas_addr[4:0]};

    initial forever begin
        @(posedge clk); #1;
        pix_ready = rnd_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (pix_valid && !fv_seen) begin fv_seen = 1'b1; t_fv = cyc; end
            if (prev_stall) chk("stall_hold", 32'({pix_valid, pix_last, pix_data}), 32'({1'b1, prev_head}));
            if (canvas_re) begin
                issued++;
                if (line_reads == 0) first_addr = canvas_addr;
                last_addr = canvas_addr;
                line_reads++;
                if (exp_addr.size() == 0) fail_now("unexpected_read");
                else chk("read_addr", 32'(canvas_addr), 32'(exp_addr.pop_front()));
                chk("credit_bound", 32'((issued - pops) <= 4), 32'd1);
            end
            if (pix_valid && pix_ready) begin
                if (exp_pix.size() == 0) fail_now("unexpected_pixel");
                else begin
                    e_pix = exp_pix.pop_front();
                    chk("pixel", 32'({pix_last, pix_data}), 32'(e_pix));
                    chk("done_with_last", 32'(line_done), 32'(e_pix[10]));
                end
                pops++;
                if (pix_last) begin last_cnt++; t_last = cyc; end
            end else if (line_done) fail_now("stray_line_done");
            if (line_done) begin done_cnt++; t_done = cyc; end
            prev_stall = pix_valid && !pix_ready;
            prev_head  = {pix_last, pix_data};
        end
    end

    task automatic start_line(input logic [7:0] n, input logic [3:0] sx, input logic [3:0] sy, input bit accept);
        logic [8:0] col;
        logic [7:0] row;
        @(posedge clk); #1;
        line_start = 1'b1; line_num = n; scroll_x = sx; scroll_y = sy;
        if (accept) begin
            t0 = cyc; fv_seen = 1'b0; line_reads = 0;
            row = n + {4'b0, sy};
            for (int i = 0; i < 320; i++) begin
                col = 9'(sx) + 9'(i);
                exp_addr.push_back({col, row});
                exp_pix.push_back({i == 319, col[4:0], row[4:0]});
            end
        end
        @(posedge clk); #1;
        line_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int start, n;
        start = done_cnt; n = 0;
        while (done_cnt == start && n < budget) begin @(negedge clk); #1; n++; end
        if (done_cnt == start) fail_now("line_done_timeout");
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_re"}, 32'(canvas_re), 0);
        chk({tag, "_addr"}, 32'(canvas_addr), 0);
        chk({tag, "_valid"}, 32'(pix_valid), 0);
        chk({tag, "_last"}, 32'(pix_last), 0);
        chk({tag, "_done"}, 32'(line_done), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, d0, l0, n;
        reset = 1'b1; line_start = 1'b0; line_num = '0; scroll_x = '0; scroll_y = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk_idle_outputs("reset");

        // Basic line: timing of first pixel, last pixel, done and busy fall
        p0 = pops;
        start_line(8'd0, 4'd0, 4'd0, 1'b1);
        wait_done(1000);
        chk("first_valid_cycle", 32'(t_fv - t0), 32'd3);
        chk("pix_last_cycle", 32'(t_last - t0), 32'd322);
        chk("line_done_cycle", 32'(t_done - t0), 32'd322);
        chk("busy_at_322", 32'(busy), 32'd1);
        @(negedge clk); #1;
        chk("busy_at_323", 32'(busy), 32'd0);
        chk("line1_count", 32'(pops - p0), 32'd320);
        chk("line1_first_addr", 32'(first_addr), 32'h00000);

        // Maximum scroll at the bottom line: col 15..334, row 254
        start_line(8'd239, 4'd15, 4'd15, 1'b1);
        wait_done(1000);
        chk("edge_first_addr", 32'(first_addr), 32'h00FFE);
        chk("edge_last_addr", 32'(last_addr), 32'h14EFE);
        chk("edge_reads", 32'(line_reads), 32'd320);

        // Random backpressure
        p0 = pops;
        rnd_ready = 1'b1;
        start_line(8'd7, 4'd5, 4'd3, 1'b1);
        wait_done(5000);
        rnd_ready = 1'b0;
        chk("stall_count", 32'(pops - p0), 32'd320);

        // Requests while busy and out-of-range requests are ignored
        start_line(8'd10, 4'd3, 4'd2, 1'b1);
        repeat (40) @(posedge clk);
        start_line(8'd5, 4'd9, 4'd9, 1'b0);
        wait_done(1000);
        d0 = done_cnt;
        start_line(8'd240, 4'd0, 4'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("reject_busy", 32'(busy), 0);
            @(negedge clk); #1;
        end
        chk("reject_no_done", 32'(done_cnt), 32'(d0));

        // Reset mid-line at pixel 100
        d0 = done_cnt; p0 = pops; n = 0;
        start_line(8'd20, 4'd1, 4'd1, 1'b1);
        while ((pops - p0) < 100 && n < 1000) begin @(negedge clk); #1; n++; end
        if ((pops - p0) < 100) fail_now("reset_wait_timeout");
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        exp_pix.delete(); exp_addr.delete();
        issued = 0; pops = 0; prev_stall = 1'b0;
        chk_idle_outputs("midreset");
        repeat (10) @(negedge clk);
        chk("midreset_no_done", 32'(done_cnt), 32'(d0));
        start_line(8'd30, 4'd2, 4'd4, 1'b1);
        wait_done(1000);
        chk("post_reset_count", 32'(pops), 32'd320);

        // Back-to-back: second request lands the cycle busy falls
        p0 = pops; d0 = done_cnt; l0 = last_cnt;
        start_line(8'd50, 4'd0, 4'd0, 1'b1);
        wait_done(1000);
        start_line(8'd51, 4'd1, 4'd1, 1'b1);
        chk("b2b_accepted", 32'(busy), 32'd1);
        wait_done(1000);
        chk("b2b_pixels", 32'(pops - p0), 32'd640);
        chk("b2b_last", 32'(last_cnt - l0), 32'd2);
        chk("b2b_done", 32'(done_cnt - d0), 32'd2);

        repeat (5) @(posedge clk);
        chk("queue_drained", 32'(exp_pix.size() + exp_addr.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
